fpu_seq: RTL
============

FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 Parameter ADD_LAT, default 1, cycles fadd needs after its operands settle (range 1..15).
REQ-002 Parameter MUL_LAT, default 1, cycles fmul needs after its operands settle (range 1..15).
REQ-003 Parameter INV_LAT, default 2, cycles finv needs after its operand settles (range 1..15).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  1  start pulse; sampled only in IDLE.
REQ-007 op  in  2  00 FADD, 01 FSUB, 10 FMUL, 11 FDIV.
REQ-008 fs, ft  in  32 each  IEEE-754 single operands; sampled with req.
REQ-009 cancel  in  1  abort of the in-flight operation.
REQ-010 fpu_a, fpu_b  out  32 each  registered operands driven to fadd/fmul (a, b) and finv (b).
REQ-011 fadd_d, fmul_d, finv_d  in  32 each  combinational unit results.
REQ-012 fadd_of, fmul_of, fmul_uf, finv_of, finv_uf  in  1 each  unit exception flags.
REQ-013 busy  out  1  high while state is not IDLE.
REQ-014 done  out  1  one-cycle pulse; result, ovf and unf are valid in that cycle.
REQ-015 result  out  32  last completed result; held until the next completion.
REQ-016 ovf, unf  out  1 each  exception flags of the last completed operation.

Function
REQ-017 States: IDLE, RUN_ADD, RUN_MUL, RUN_INV; 4-bit down-counter cnt.
REQ-018 IDLE & req & ~cancel: fpu_a<=fs; fpu_b<=ft for op 00/10/11, {~ft[31],ft[30:0]} for op 01.
REQ-019 Same edge: op 00/01 -> RUN_ADD with cnt<=ADD_LAT-1; op 10 -> RUN_MUL with cnt<=MUL_LAT-1; op 11 -> RUN_INV with cnt<=INV_LAT-1.
REQ-020 RUN_* with cnt!=0: cnt decrements by 1; nothing else changes.
REQ-021 RUN_ADD, cnt==0: result<=fadd_d, ovf<=fadd_of, unf<=0, done<=1, state<=IDLE.
REQ-022 RUN_MUL, cnt==0: result<=fmul_d, ovf<=fmul_of|inv_of_s, unf<=fmul_uf|inv_uf_s, done<=1, state<=IDLE.
REQ-023 RUN_INV, cnt==0: fpu_b<=finv_d, inv_of_s<=finv_of, inv_uf_s<=finv_uf, cnt<=MUL_LAT-1, state<=RUN_MUL; no done pulse.
REQ-024 inv_of_s and inv_uf_s clear on every accepted req, so that FADD/FSUB/FMUL report only their own flags.
REQ-025 Latency from the req cycle to the done cycle: ADD_LAT+1 for FADD/FSUB, MUL_LAT+1 for FMUL, INV_LAT+MUL_LAT+1 for FDIV.
REQ-026 done is registered, high exactly one cycle, and low in every cycle not covered by REQ-021 or REQ-022.
REQ-027 busy is combinational from state: high from the cycle after acceptance through the last RUN cycle, low in the done cycle.
REQ-028 A req arriving while busy is ignored, not queued, and has no effect.
REQ-029 A req in the done cycle is accepted, giving back-to-back operation with no bubble.
REQ-030 cancel while busy: next edge returns to IDLE; no done; result, ovf and unf keep their prior values.
REQ-031 cancel in IDLE: no effect; if asserted together with req, cancel wins and req is dropped.
REQ-032 cancel in the completing cycle (cnt==0 in RUN_ADD/RUN_MUL): cancel wins; no done, no result update.
REQ-033 Flag inputs are sampled only at the capture edges of REQ-021..REQ-023.

Reset
REQ-034 rst: state<=IDLE, cnt<=0, done<=0, result<=0, ovf<=0, unf<=0, fpu_a<=0, fpu_b<=0, inv_of_s<=0, inv_uf_s<=0.
REQ-035 rst asserted mid-operation aborts it with no done pulse; rst has priority over req, cancel and completion.
REQ-036 First req accepted on the first edge at which rst is low.

Verification
REQ-037 Defaults, FADD fs=0x3F800000, ft=0x40000000 -> done 2 cycles after req, result=0x40400000, ovf=0, unf=0.
REQ-038 FSUB fs=0x40400000, ft=0x3F800000 -> fpu_b=0xBF800000, result=0x40000000.
REQ-039 FDIV fs=0x3F800000, ft=0x40000000 (defaults) -> fpu_b=0x3F000000 after the INV phase; done 4 cycles after req; result=0x3F000000.
REQ-040 FMUL 0x7F000000 x 0x7F000000 -> ovf=1; a following FADD 1.0+1.0 -> ovf=0, result=0x40000000.
REQ-041 FADD accepted, req re-pulsed while busy, then cancel next cycle -> no done, result unchanged, busy=0; new req accepted the cycle after.
REQ-042 Back-to-back: req in every done cycle for 4 ops -> 4 done pulses, each result correct; rst mid-FDIV -> all outputs zero, no done.

Source files
------------

// File: rtl/fpu_seq.sv
// Sequencer for an external single-precision fadd/fmul/finv datapath.
// Latches operands, waits the configured unit latency, captures the result
// and exception flags, and chains finv -> fmul to implement division.
module fpu_seq #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned INV_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  input  logic        cancel,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fadd_d,
  input  logic [31:0] fmul_d,
  input  logic [31:0] finv_d,
  input  logic        fadd_of,
  input  logic        fmul_of,
  input  logic        fmul_uf,
  input  logic        finv_of,
  input  logic        finv_uf,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN_ADD = 2'b01,
    RUN_MUL = 2'b10,
    RUN_INV = 2'b11
  } state_t;

  // Counter preload values: the counter reaches zero on the capture cycle.
  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] INV_CNT = 4'(INV_LAT - 1);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_done, w_done_nx;
  logic [31:0] r_result, w_result_nx;
  logic        r_ovf, w_ovf_nx;
  logic        r_unf, w_unf_nx;
  logic [31:0] r_fpu_a, w_fpu_a_nx;
  logic [31:0] r_fpu_b, w_fpu_b_nx;
  logic        r_inv_of, w_inv_of_nx;
  logic        r_inv_uf, w_inv_uf_nx;

  // Next-state and next-value logic; every register holds unless a rule below fires.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_done_nx   = 1'b0;
    w_result_nx = r_result;
    w_ovf_nx    = r_ovf;
    w_unf_nx    = r_unf;
    w_fpu_a_nx  = r_fpu_a;
    w_fpu_b_nx  = r_fpu_b;
    w_inv_of_nx = r_inv_of;
    w_inv_uf_nx = r_inv_uf;
    case (r_state)
      IDLE: begin
        if (req && !cancel) begin
          // Inverse flags belong to one division only; clear them per operation.
          w_fpu_a_nx  = fs;
          w_inv_of_nx = 1'b0;
          w_inv_uf_nx = 1'b0;
          case (op)
            2'b00: begin
              w_fpu_b_nx = ft;
              w_state_nx = RUN_ADD;
              w_cnt_nx   = ADD_CNT;
            end
            2'b01: begin
              // Subtraction reuses the adder with the second operand negated.
              w_fpu_b_nx = {~ft[31], ft[30:0]};
              w_state_nx = RUN_ADD;
              w_cnt_nx   = ADD_CNT;
            end
            2'b10: begin
              w_fpu_b_nx = ft;
              w_state_nx = RUN_MUL;
              w_cnt_nx   = MUL_CNT;
            end
            default: begin
              w_fpu_b_nx = ft;
              w_state_nx = RUN_INV;
              w_cnt_nx   = INV_CNT;
            end
          endcase
        end else begin
          w_state_nx = IDLE;
        end
      end
      RUN_ADD: begin
        if (cancel) begin
          w_state_nx = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_result_nx = fadd_d;
          w_ovf_nx    = fadd_of;
          w_unf_nx    = 1'b0;
          w_done_nx   = 1'b1;
          w_state_nx  = IDLE;
        end
      end
      RUN_MUL: begin
        if (cancel) begin
          w_state_nx = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          // Division reports the union of its inverse and multiply flags.
          w_result_nx = fmul_d;
          w_ovf_nx    = fmul_of | r_inv_of;
          w_unf_nx    = fmul_uf | r_inv_uf;
          w_done_nx   = 1'b1;
          w_state_nx  = IDLE;
        end
      end
      RUN_INV: begin
        if (cancel) begin
          w_state_nx = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          // Feed 1/ft back into the multiplier's b operand and start the multiply.
          w_fpu_b_nx  = finv_d;
          w_inv_of_nx = finv_of;
          w_inv_uf_nx = finv_uf;
          w_cnt_nx    = MUL_CNT;
          w_state_nx  = RUN_MUL;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_fpu_a  <= 32'd0;
      r_fpu_b  <= 32'd0;
      r_inv_of <= 1'b0;
      r_inv_uf <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_done   <= w_done_nx;
      r_result <= w_result_nx;
      r_ovf    <= w_ovf_nx;
      r_unf    <= w_unf_nx;
      r_fpu_a  <= w_fpu_a_nx;
      r_fpu_b  <= w_fpu_b_nx;
      r_inv_of <= w_inv_of_nx;
      r_inv_uf <= w_inv_uf_nx;
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign fpu_a  = r_fpu_a;
  assign fpu_b  = r_fpu_b;

endmodule
